// File: rtl/mem_test_ctrl_if.sv
// rtl/mem_test_ctrl_if.sv - memory/comparator bus between the test controller and the memory under test
interface mem_test_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) ();
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] data_gen;
  logic              is_equal;

  modport master (
    output mem_we,
    output mem_re,
    output mem_addr,
    output data_gen,
    input  is_equal
  );

  modport slave (
    input  mem_we,
    input  mem_re,
    input  mem_addr,
    input  data_gen,
    output is_equal
  );
endinterface

// File: rtl/mem_test_ctrl.sv
// rtl/mem_test_ctrl.sv - two-phase (address / complemented address) write-read-compare memory test controller
module mem_test_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  mem_test_ctrl_if.master       mem,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            err_cnt,
  output logic [ADDR_W-1:0]     fail_addr,
  output logic                  fail_phase
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_CMP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [7:0]        ERR_MAX   = 8'hFF;

  state_t            state_q, state_d;
  logic              phase_q, phase_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic              fail_phase_q, fail_phase_d;
  logic [DATA_W-1:0] pattern;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      phase_q      <= 1'b0;
      addr_q       <= '0;
      err_cnt_q    <= '0;
      fail_addr_q  <= '0;
      fail_phase_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      addr_q       <= addr_d;
      err_cnt_q    <= err_cnt_d;
      fail_addr_q  <= fail_addr_d;
      fail_phase_q <= fail_phase_d;
    end
  end

  // Address-as-data pattern: wide addresses are truncated, narrow ones zero-extended.
  if (ADDR_W >= DATA_W) begin : g_pat_trunc
    assign pattern = addr_q[DATA_W-1:0];
  end else begin : g_pat_ext
    assign pattern = {{(DATA_W-ADDR_W){1'b0}}, addr_q};
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    addr_d       = addr_q;
    err_cnt_d    = err_cnt_q;
    fail_addr_d  = fail_addr_q;
    fail_phase_d = fail_phase_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_WR;
          phase_d      = 1'b0;
          addr_d       = '0;
          err_cnt_d    = '0;
          fail_addr_d  = '0;
          fail_phase_d = 1'b0;
        end
      end

      S_WR: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_RD;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end

      S_RD: begin
        state_d = S_CMP;
      end

      S_CMP: begin
        if (!mem.is_equal) begin
          // A zero count means no earlier mismatch in this run, so this one is the first.
          if (err_cnt_q == 8'd0) begin
            fail_addr_d  = addr_q;
            fail_phase_d = phase_q;
          end
          if (err_cnt_q != ERR_MAX) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end

        if (addr_q != LAST_ADDR) begin
          state_d = S_RD;
          addr_d  = addr_q + ADDR_W'(1);
        end else if (!phase_q) begin
          state_d = S_WR;
          phase_d = 1'b1;
          addr_d  = '0;
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem.mem_we   = (state_q == S_WR);
  assign mem.mem_re   = (state_q == S_RD);
  assign mem.mem_addr = addr_q;
  assign mem.data_gen = pattern ^ {DATA_W{phase_q}};

  assign busy       = (state_q == S_WR) || (state_q == S_RD) || (state_q == S_CMP);
  assign done       = (state_q == S_DONE);
  assign pass       = (err_cnt_q == 8'd0);
  assign err_cnt    = err_cnt_q;
  assign fail_addr  = fail_addr_q;
  assign fail_phase = fail_phase_q;

endmodule

// File: tb/tb_mem_test_ctrl.sv
// tb/tb_mem_test_ctrl.sv - scoreboard bench for mem_test_ctrl with a fault-injecting memory model
module tb_mem_test_ctrl;
  localparam int DW     = 8;
  localparam int AW     = 4;
  localparam int DEPTH  = 16;
  localparam int AWB    = 8;
  localparam int DEPTHB = 256;

  typedef struct {
    int err;
    int faddr;
    int fphase;
    int pass_;
    int done_cyc;
  } res_t;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_test_ctrl_if #(.DATA_W(DW), .ADDR_W(AW))  bus_a ();
  mem_test_ctrl_if #(.DATA_W(DW), .ADDR_W(AWB)) bus_b ();

  logic          busy_a, done_a, pass_a, fail_phase_a;
  logic [7:0]    err_a;
  logic [AW-1:0] fail_addr_a;
  logic          busy_b, done_b, pass_b, fail_phase_b;
  logic [7:0]    err_b;
  logic [AWB-1:0] fail_addr_b;

  mem_test_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mem(bus_a.master),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .fail_addr(fail_addr_a), .fail_phase(fail_phase_a)
  );

  mem_test_ctrl #(.DATA_W(DW), .ADDR_W(AWB)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mem(bus_b.master),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .fail_addr(fail_addr_b), .fail_phase(fail_phase_b)
  );

  int n_chk = 0;
  int n_ok  = 0;

  function automatic void chk(string name, longint act, longint exp);
    n_chk++;
    if (act == exp) n_ok++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // Fault configuration: one bit of one address stuck at f_val.
  bit f_en = 0;
  int f_addr = 0;
  int f_bit = 0;
  bit f_val = 0;

  function automatic logic [7:0] faulty(input int a, input logic [7:0] w);
    logic [7:0] r;
    r = w;
    if (f_en && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  logic [7:0] mem_a [DEPTH];
  logic [7:0] rdata_a;
  logic       rvalid_a = 1'b0;
  logic       noise_a = 1'b0;

  always @(posedge clk) begin
    if (bus_a.mem_we) mem_a[bus_a.mem_addr] <= faulty(int'(bus_a.mem_addr), bus_a.data_gen);
    if (bus_a.mem_re) rdata_a <= mem_a[bus_a.mem_addr];
    rvalid_a <= bus_a.mem_re;
  end

  always @(negedge clk) noise_a <= 1'($urandom);

  // Comparator output is only meaningful the cycle after a read; elsewhere it is random junk.
  assign bus_a.is_equal = rvalid_a ? (rdata_a == bus_a.data_gen) : noise_a;
  assign bus_b.is_equal = 1'b0;

  res_t exp_q[$];
  res_t exp_b_q[$];
  wr_t  wr_q[$];

  function automatic void push_run(input int start_edge);
    res_t r;
    logic [7:0] w;
    r.err = 0; r.faddr = 0; r.fphase = 0;
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < DEPTH; a++) begin
        w = 8'(a) ^ (p != 0 ? 8'hFF : 8'h00);
        wr_q.push_back('{addr: a, data: int'(w)});
        if (faulty(a, w) != w) begin
          if (r.err == 0) begin r.faddr = a; r.fphase = p; end
          if (r.err < 255) r.err++;
        end
      end
    end
    r.pass_ = (r.err == 0) ? 1 : 0;
    r.done_cyc = start_edge + 6 * DEPTH;
    exp_q.push_back(r);
  endfunction

  function automatic void push_run_b(input int start_edge);
    res_t r;
    r.err = 0; r.faddr = 0; r.fphase = 0;
    for (int k = 0; k < 2 * DEPTHB; k++) begin
      if (r.err == 0) begin r.faddr = k % DEPTHB; r.fphase = k / DEPTHB; end
      if (r.err < 255) r.err++;
    end
    r.pass_ = (r.err == 0) ? 1 : 0;
    r.done_cyc = start_edge + 6 * DEPTHB;
    exp_b_q.push_back(r);
  endfunction

  logic done_prev_a = 1'b0;
  logic done_prev_b = 1'b0;
  logic overlap_seen = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if ((bus_a.mem_we && bus_a.mem_re) || (!busy_a && (bus_a.mem_we || bus_a.mem_re)))
        overlap_seen <= 1'b1;
      if (bus_a.mem_we) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("wr_addr", bus_a.mem_addr, w.addr);
          chk("wr_data", bus_a.data_gen, w.data);
        end
      end
      if (done_a && !done_prev_a) begin
        if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          res_t r;
          r = exp_q.pop_front();
          chk("done_cycle", cyc, r.done_cyc);
          chk("err_cnt", err_a, r.err);
          chk("fail_addr", fail_addr_a, r.faddr);
          chk("fail_phase", fail_phase_a, r.fphase);
          chk("pass", pass_a, r.pass_);
        end
      end
      if (done_b && !done_prev_b) begin
        if (exp_b_q.size() == 0) chk("done_b_unexpected", 1, 0);
        else begin
          res_t r;
          r = exp_b_q.pop_front();
          chk("b_done_cycle", cyc, r.done_cyc);
          chk("b_err_cnt", err_b, r.err);
          chk("b_fail_addr", fail_addr_b, r.faddr);
          chk("b_fail_phase", fail_phase_b, r.fphase);
          chk("b_pass", pass_b, r.pass_);
        end
      end
    end
    done_prev_a <= done_a;
    done_prev_b <= done_b;
  end

  task automatic check_reset_a();
    chk("rst_we", bus_a.mem_we, 0);
    chk("rst_re", bus_a.mem_re, 0);
    chk("rst_addr", bus_a.mem_addr, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_fail_addr", fail_addr_a, 0);
    chk("rst_fail_phase", fail_phase_a, 0);
    chk("rst_pass", pass_a, 1);
  endtask

  // Starts a run on DUT A and waits (bounded) for done; optionally pulses start mid-run.
  task automatic run_a(input bit noisy);
    int  se;
    bit  seen;
    @(posedge clk); #1;
    start_a = 1'b1;
    se = cyc + 1;
    push_run(se);
    @(posedge clk); #1;
    start_a = 1'b0;
    seen = 0;
    for (int i = 0; i < 6 * DEPTH + 20 && !seen; i++) begin
      if (noisy && i < 6 * DEPTH - 4) start_a = 1'($urandom);
      else start_a = 1'b0;
      @(negedge clk);
      if (done_a) seen = 1;
      @(posedge clk); #1;
    end
    start_a = 1'b0;
    chk("run_timeout", seen, 1);
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_a();
    @(posedge clk); #1;
    rst = 1'b0;

    // Fault-free, then bit0 stuck-at-1 at address 5, then restart straight from DONE.
    f_en = 0;
    run_a(1'b0);
    f_en = 1; f_addr = 5; f_bit = 0; f_val = 1'b1;
    run_a(1'b0);
    f_en = 0;
    run_a(1'b0);

    for (int k = 0; k < 4; k++) begin
      f_en = 1;
      f_addr = int'($urandom_range(DEPTH - 1, 0));
      f_bit = int'($urandom_range(7, 0));
      f_val = 1'($urandom);
      run_a(1'b1);
    end

    // Mid-run reset, with start asserted on the same edge to exercise priority.
    f_en = 1; f_addr = 3; f_bit = 1; f_val = 1'b0;
    begin
      int se;
      @(posedge clk); #1;
      start_a = 1'b1;
      se = cyc + 1;
      push_run(se);
      @(posedge clk); #1;
      start_a = 1'b0;
      while (cyc < se + 39) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("pre_rst_err", err_a, 1);
      chk("pre_rst_busy", busy_a, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      start_a = 1'b1;
      wr_q.delete();
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      start_a = 1'b0;
      @(negedge clk);
      check_reset_a();
    end
    f_en = 0;
    run_a(1'b1);

    // Wide instance with a comparator stuck at "not equal": count must saturate.
    begin
      int  se;
      bit  seen;
      @(posedge clk); #1;
      start_b = 1'b1;
      se = cyc + 1;
      push_run_b(se);
      @(posedge clk); #1;
      start_b = 1'b0;
      seen = 0;
      for (int i = 0; i < 6 * DEPTHB + 20 && !seen; i++) begin
        @(negedge clk);
        if (done_b) seen = 1;
      end
      chk("b_run_timeout", seen, 1);
    end

    @(posedge clk); #1;
    @(negedge clk);
    chk("we_re_protocol", overlap_seen, 0);
    chk("wr_q_drained", wr_q.size(), 0);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("exp_b_q_drained", exp_b_q.size(), 0);
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
